// File: rtl/mcu_nbit_pkg.sv
// Shared opcode encodings and control-state type for the N-bit accumulator MCU.
package mcu_nbit_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    INIT,
    FETCH,
    DECODE,
    EXECUTE,
    HALT
  } core_state_e;

endpackage

// File: rtl/mcu_nbit_core_alu.sv
// Combinational ALU for the arithmetic, logic and shift opcodes (ADD..SHR).
// Carry is zero for the logic operations so the core can load it unconditionally.
module alu_nbit
  import mcu_nbit_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  logic [DATA_WIDTH:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign zero = (result == '0);

  // Select the operation result and its carry/borrow for the current opcode
  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_WIDTH-1:0];
        carry  = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DATA_WIDTH-2:0], 1'b0};
        carry  = a[DATA_WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_WIDTH-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcu_nbit_core.sv
// Parametrised accumulator MCU: INIT/FETCH/DECODE/EXECUTE/HALT control with a
// handshaked instruction fetch, register file, persistent Z/C flags and jumps.
module mcu_nbit_core
  import mcu_nbit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 8,
  parameter int REG_COUNT  = 16,
  parameter int OPD_WIDTH  = $clog2(REG_COUNT)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [PC_WIDTH-1:0]    resetPC,
  output logic                   instr_req,
  input  logic                   instr_valid,
  input  logic [3+OPD_WIDTH:0]   instr,
  output logic [PC_WIDTH-1:0]    currentPC,
  output logic [DATA_WIDTH-1:0]  acc_out,
  output logic                   flag_z,
  output logic                   flag_c,
  output logic                   halted
);

  localparam int INSTR_WIDTH = 4 + OPD_WIDTH;
  localparam int IDX_WIDTH   = $clog2(REG_COUNT);

  core_state_e state, state_next;

  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]  opd_latch;
  logic                   zf, cf;
  logic [DATA_WIDTH-1:0]  reg_file [REG_COUNT];

  logic [3:0]            opcode;
  logic [OPD_WIDTH-1:0]  operand;
  logic [IDX_WIDTH-1:0]  reg_idx;
  logic [DATA_WIDTH-1:0] imm;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry, alu_zero;

  logic [DATA_WIDTH-1:0] acc_next;
  logic                  z_next, c_next, reg_we, jump_taken;

  assign opcode  = ir[INSTR_WIDTH-1 -: 4];
  assign operand = ir[OPD_WIDTH-1:0];
  assign reg_idx = operand[IDX_WIDTH-1:0];
  assign imm     = DATA_WIDTH'(operand);

  assign instr_req = (state == FETCH);
  assign halted    = (state == HALT);
  assign currentPC = pc;
  assign acc_out   = acc;
  assign flag_z    = zf;
  assign flag_c    = cf;

  alu_nbit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a      (acc),
    .b      (opd_latch),
    .op     (opcode),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Control state register; reset always restarts from INIT
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= INIT;
    else       state <= state_next;
  end

  // Next-state logic; FETCH waits for the memory handshake, HALT is absorbing
  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = FETCH;
      FETCH:   if (instr_valid) state_next = DECODE;
      DECODE:  state_next = EXECUTE;
      EXECUTE: state_next = (opcode == OP_HLT) ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = INIT;
    endcase
  end

  // Instruction effects computed from IR and operand latch, committed in EXECUTE
  always_comb begin
    acc_next   = acc;
    z_next     = zf;
    c_next     = cf;
    reg_we     = 1'b0;
    jump_taken = 1'b0;
    case (opcode)
      OP_LDI: begin
        acc_next = imm;
        z_next   = (imm == '0);
      end
      OP_LDR: begin
        acc_next = opd_latch;
        z_next   = (opd_latch == '0);
      end
      OP_STR: reg_we = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        acc_next = alu_result;
        z_next   = alu_zero;
        c_next   = alu_carry;
      end
      OP_JMP: jump_taken = 1'b1;
      OP_JZ:  jump_taken = zf;
      OP_JC:  jump_taken = cf;
      OP_NOP, OP_HLT: ;
      default: ;
    endcase
  end

  // PC, IR, accumulator, flags and operand latch sequencing
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      opd_latch <= '0;
      zf        <= 1'b0;
      cf        <= 1'b0;
    end else begin
      case (state)
        INIT: pc <= resetPC;
        FETCH: begin
          if (instr_valid) begin
            ir <= instr;
            pc <= pc + PC_WIDTH'(1);
          end
        end
        DECODE: opd_latch <= reg_file[reg_idx];
        EXECUTE: begin
          acc <= acc_next;
          zf  <= z_next;
          cf  <= c_next;
          if (jump_taken) pc <= opd_latch[PC_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // Register file; a store lands at the end of EXECUTE, ahead of the next DECODE
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < REG_COUNT; i++) reg_file[i] <= '0;
    end else if (state == EXECUTE && reg_we) begin
      reg_file[reg_idx] <= acc;
    end
  end

endmodule

// File: doc/mcu_nbit_core.md
# mcu_nbit_core

Parametrised successor to the 8-bit accumulator MCU. It keeps the accumulator / register-file / ALU datapath and adds the following:
- configurable data width, PC width and register count;
- persistent Z/C flags with conditional jumps;
- a valid-handshake instruction fetch that tolerates wait states;
- a HALT state.

It sits between an external instruction memory, which returns words over the fetch handshake, and the SoC top level, which observes PC, accumulator and status.

## Interface
Parameters:
- DATA_WIDTH, 8, accumulator/register/ALU width (≥4)
- PC_WIDTH, 8, program-counter and jump-target width (≤ DATA_WIDTH)
- REG_COUNT, 16, register-file depth (power of two, ≥2)
- OPD_WIDTH, $clog2(REG_COUNT), operand field width; instruction width is 4+OPD_WIDTH

Ports:
- Clk, in, 1, sole clock; all state updates on rising edge
- Reset, in, 1, asynchronous, active-high; clears all state
- resetPC, in, PC_WIDTH, start address loaded after Reset deasserts
- instr_req, out, 1, fetch request; high for the whole of FETCH
- instr_valid, in, 1, memory asserts when instr is valid for currentPC
- instr, in, 4+OPD_WIDTH, {opcode[3:0], operand}
- currentPC, out, PC_WIDTH, address being fetched
- acc_out, out, DATA_WIDTH, accumulator value
- flag_z, out, 1, zero flag
- flag_c, out, 1, carry/borrow flag
- halted, out, 1, high in HALT state

## Operation
- States are INIT, FETCH, DECODE, EXECUTE and HALT.
- Async Reset forces INIT. In INIT: PC←resetPC, then FETCH.
- **FETCH:** instr_req=1. When instr_valid=1, latch instr into IR, PC←PC+1 (wraps modulo 2^PC_WIDTH), go to DECODE. Otherwise hold state; PC and IR are unchanged.
- **DECODE:** read R[operand] into an operand latch.
- **EXECUTE:** perform the operation, then go to FETCH. HLT goes to HALT instead.
- **HALT:** absorbing; instr_req=0. Only Reset exits.
- Opcodes: R means R[operand]; imm is the operand zero-extended.
  - 0 NOP
  - 1 LDI: acc←imm
  - 2 LDR: acc←R
  - 3 STR: R←acc
  - 4 ADD: {C,acc}←acc+R
  - 5 SUB: acc←acc−R, C←(acc<R)
  - 6 AND, 7 OR, 8 XOR: acc←acc op R
  - 9 NOT: acc←~acc, operand ignored
  - A SHL: C←acc[MSB], acc←acc<<1
  - B SHR: C←acc[0], acc←acc>>1
  - C JMP: PC←R[PC_WIDTH−1:0]
  - D JZ: jump if Z
  - E JC: jump if C
  - F HLT
- Flag update rules:
  - Z←(new acc==0) on opcodes 1,2,4–B.
  - C is written by 4,5,A,B and cleared by 6–9.
  - All other opcodes leave both flags unchanged.
- A jump taken in EXECUTE overrides the increment performed in FETCH. A jump not taken leaves PC at PC+1.
- STR to any register is visible to the next instruction's DECODE.
- The register file, acc, flags and IR reset to 0.

## Timing
- Reset values: currentPC=0, acc_out=0, flag_z=0, flag_c=0, halted=0, instr_req=0.
- The first instr_req=1 occurs two cycles after Reset falls: INIT, then FETCH.
- With zero-wait memory (instr_valid high in the first FETCH cycle), every instruction takes exactly 3 cycles.
- Each wait cycle adds 1.
- acc, flags and PC (on a jump) update at the EXECUTE→FETCH edge. The next FETCH presents the new currentPC.
- instr_valid is ignored outside FETCH.
- instr is sampled only on the FETCH cycle where instr_valid=1.
- currentPC is stable for the whole FETCH state.
- Reset asserted mid-instruction aborts immediately: all state is cleared asynchronously, and a pending register write is lost.
- PC increment from all-ones wraps to 0.
- Register index is the operand's low log2(REG_COUNT) bits.

## Structure
- Package mcu_nbit_pkg holds:
  - the opcode localparams (OP_NOP … OP_HLT);
  - the state enum (INIT, FETCH, DECODE, EXECUTE, HALT).
- Sub-module alu_nbit: combinational and parametrised by DATA_WIDTH. Inputs are a, b and op[3:0]; outputs are result, carry and zero. It covers opcodes 4–B.
- Register file, FSM, PC and IR stay in the core.

## Test plan
- **Reset and first fetch.** Reset 3 cycles with resetPC=8'h10, zero-wait memory. Expect currentPC=0 during reset, then 8'h10 at the first instr_req, then 8'h11 in the next FETCH.
- **Load, store, add, sub.** Program LDI 5; STR R1; LDI 3; ADD R1; SUB R1; SUB R1.
  - acc=8 after the ADD.
  - acc=3 after the first SUB.
  - acc=8'hFE with C=1, Z=0 after the second SUB.
  - 18 cycles total.
- **Wait-state stall.** Hold instr_valid low for 4 cycles during a FETCH. Expect FETCH to persist with currentPC stable and instr_req=1, and PC incremented exactly once.
- **Conditional jumps.**
  - LDI 0 (Z=1); JZ R2 with R2=8'h40: currentPC=8'h40 at the next FETCH.
  - With Z=0: currentPC=PC+1.
  - SHL of 8'h80 sets C=1 and acc=0; a following JC is taken.
- **HLT and restart.** HLT asserts halted=1 with instr_req=0 indefinitely. Reset then returns the core to INIT with halted=0.
- **Parameter sweep.** DATA_WIDTH=16, PC_WIDTH=12, REG_COUNT=8: ADD 16'hFFFF+1 gives acc=0, C=1, Z=1. PC wrap from 12'hFFF goes to 0.
